game_draw_sequencer: RTL and testbench

- FSM controller for the game-state drawing datapath. Sequences screen clear, grid draw, level-board draw and number redraws by driving one-hot enables (clear, drawGrid, drawEZ/drawNORMAL/drawHARD, drawNum).
- The datapath drawers report no completion, so each phase runs for a fixed, parameterised cycle count.
- Also arbitrates redraw requests and game-over events from game logic, and pulses level_loaded so game logic samples the initial board and timer values.

---
 rtl/game_draw_sequencer.sv | 173 +++++++++++++++++
 tb/tb_game_draw_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_draw_sequencer.sv
// ---------------------------------------------------------------------------
// game_draw_sequencer
//
// Controller for the game-state drawing datapath. A game starts with a
// full-screen clear, then the grid, then the level board chosen by the
// latched difficulty. After that the machine sits in PLAY and serves
// redraw requests (one drawNum pass) and game-over events (end-of-game
// clear back to IDLE). The datapath drawers give no completion signal, so
// each phase is held for a fixed number of cycles.
//
// Ports
//   clk           system clock
//   resetn        asynchronous active-low reset
//   start         begin a game (only looked at in IDLE)
//   difficulty    00=EZ, 01=NORMAL, 1x=HARD; latched when start is taken
//   redraw_req    board changed, request a drawNum pass
//   game_over     win or timeout, request the end-of-game clear
//   clear         datapath clear enable
//   drawGrid      datapath grid enable
//   drawEZ        easy level-board enable
//   drawNORMAL    normal level-board enable
//   drawHARD      hard level-board enable
//   drawNum       live-board number enable
//   plot          VGA write enable, OR of the six enables
//   busy          high in every state except IDLE and PLAY
//   ready         high only in PLAY
//   level_loaded  one-cycle pulse on the first PLAY cycle after LEVEL
// ---------------------------------------------------------------------------
module game_draw_sequencer #(
    parameter int CLEAR_CYCLES = 19200,
    parameter int GRID_CYCLES  = 4096,
    parameter int NUM_CYCLES   = 4096,
    parameter int CNT_W        = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] difficulty,
    input  logic       redraw_req,
    input  logic       game_over,
    output logic       clear,
    output logic       drawGrid,
    output logic       drawEZ,
    output logic       drawNORMAL,
    output logic       drawHARD,
    output logic       drawNum,
    output logic       plot,
    output logic       busy,
    output logic       ready,
    output logic       level_loaded
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR     = 3'd1,
        GRID    = 3'd2,
        LEVEL   = 3'd3,
        PLAY    = 3'd4,
        NUM     = 3'd5,
        END_CLR = 3'd6
    } state_t;

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GRID_LAST  = CNT_W'(GRID_CYCLES - 1);
    localparam logic [CNT_W-1:0] NUM_LAST   = CNT_W'(NUM_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       diff_q;
    logic             pend_redraw;
    logic             pend_over;
    logic             phase_last;

    // Decide whether the current timed phase is on its final cycle. The
    // level board and the number redraw share the same length. An encoding
    // outside the enum counts as "last" so the machine falls back to IDLE
    // instead of counting forever.
    always_comb begin
        phase_last = 1'b0;
        case (state)
            CLR, END_CLR: phase_last = (cnt == CLEAR_LAST);
            GRID:         phase_last = (cnt == GRID_LAST);
            LEVEL, NUM:   phase_last = (cnt == NUM_LAST);
            IDLE, PLAY:   phase_last = 1'b0;
            default:      phase_last = 1'b1;
        endcase
    end

    // Main sequencer. IDLE waits for start and keeps the pending flags
    // clear. Timed states count up and advance on their last cycle, while
    // collecting redraw/game-over requests so none is lost mid-phase
    // (except during the end-of-game clear, where they are meaningless).
    // PLAY serves game-over before redraw; a simultaneous redraw is dropped
    // because the board is about to be wiped anyway. level_loaded is
    // registered so it lines up with the first PLAY cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            diff_q       <= 2'b00;
            pend_redraw  <= 1'b0;
            pend_over    <= 1'b0;
            level_loaded <= 1'b0;
        end else begin
            level_loaded <= 1'b0;
            case (state)
                IDLE: begin
                    cnt         <= '0;
                    pend_redraw <= 1'b0;
                    pend_over   <= 1'b0;
                    if (start) begin
                        diff_q <= difficulty;
                        state  <= CLR;
                    end
                end
                PLAY: begin
                    cnt <= '0;
                    if (game_over || pend_over) begin
                        state       <= END_CLR;
                        pend_over   <= 1'b0;
                        pend_redraw <= 1'b0;
                    end else if (redraw_req || pend_redraw) begin
                        state       <= NUM;
                        pend_redraw <= 1'b0;
                    end
                end
                default: begin
                    if (state != END_CLR) begin
                        pend_over   <= pend_over | game_over;
                        pend_redraw <= pend_redraw | redraw_req;
                    end
                    if (phase_last) begin
                        cnt <= '0;
                        case (state)
                            CLR:   state <= GRID;
                            GRID:  state <= LEVEL;
                            LEVEL: begin
                                state        <= PLAY;
                                level_loaded <= 1'b1;
                            end
                            NUM:   state <= PLAY;
                            END_CLR: begin
                                state       <= IDLE;
                                diff_q      <= 2'b00;
                                pend_over   <= 1'b0;
                                pend_redraw <= 1'b0;
                            end
                            default: state <= IDLE;
                        endcase
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Moore decodes of the state register. Only one state is active at a
    // time, so at most one enable can be high in any cycle.
    always_comb begin
        clear      = (state == CLR) || (state == END_CLR);
        drawGrid   = (state == GRID);
        drawEZ     = (state == LEVEL) && (diff_q == 2'b00);
        drawNORMAL = (state == LEVEL) && (diff_q == 2'b01);
        drawHARD   = (state == LEVEL) && diff_q[1];
        drawNum    = (state == NUM);
        plot       = clear | drawGrid | drawEZ | drawNORMAL | drawHARD | drawNum;
        busy       = (state != IDLE) && (state != PLAY);
        ready      = (state == PLAY);
    end

endmodule

// File: tb/tb_game_draw_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_draw_sequencer
//
// Bench for game_draw_sequencer with short phases (clear 8, grid 4, number
// 6). A phase-list reference model predicts every output each cycle; the
// directed scenarios additionally check cycle windows written out as plain
// ranges.
// ---------------------------------------------------------------------------
module tb_game_draw_sequencer;

    localparam int CLR_N  = 8;
    localparam int GRID_N = 4;
    localparam int NUM_N  = 6;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] difficulty;
    logic       redraw_req;
    logic       game_over;
    logic       clear, drawGrid, drawEZ, drawNORMAL, drawHARD, drawNum;
    logic       plot, busy, ready, level_loaded;
    logic [9:0] obs;

    int checks   = 0;
    int failures = 0;

    game_draw_sequencer #(
        .CLEAR_CYCLES(CLR_N),
        .GRID_CYCLES (GRID_N),
        .NUM_CYCLES  (NUM_N),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .difficulty  (difficulty),
        .redraw_req  (redraw_req),
        .game_over   (game_over),
        .clear       (clear),
        .drawGrid    (drawGrid),
        .drawEZ      (drawEZ),
        .drawNORMAL  (drawNORMAL),
        .drawHARD    (drawHARD),
        .drawNum     (drawNum),
        .plot        (plot),
        .busy        (busy),
        .ready       (ready),
        .level_loaded(level_loaded)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    assign obs = {clear, drawGrid, drawEZ, drawNORMAL, drawHARD, drawNum,
                  plot, busy, ready, level_loaded};

    // Reference model: the current drawing phase with its remaining
    // length, plus a list of phases still to run for the start sequence.
    typedef enum int {M_IDLE, M_PLAY, M_CLEAR, M_GRID, M_LEVEL, M_NUM, M_END} mphase_t;

    mphase_t    m_ph;
    int         m_left;
    mphase_t    m_todo[$];
    logic [1:0] m_diff;
    bit         m_po, m_pr, m_ll;

    function automatic int phase_len(input mphase_t p);
        case (p)
            M_CLEAR, M_END: return CLR_N;
            M_GRID:         return GRID_N;
            default:        return NUM_N;
        endcase
    endfunction

    task automatic model_reset();
        m_ph   = M_IDLE;
        m_left = 0;
        m_todo.delete();
        m_diff = 2'b00;
        m_po   = 0;
        m_pr   = 0;
        m_ll   = 0;
    endtask

    task automatic model_enter(input mphase_t p);
        m_ph   = p;
        m_left = phase_len(p);
    endtask

    // Advance the model by one clock edge using the inputs held before it.
    task automatic model_step(input bit st, input logic [1:0] d, input bit rr, input bit go);
        m_ll = 0;
        case (m_ph)
            M_IDLE: begin
                if (st) begin
                    m_diff = d;
                    m_todo.delete();
                    m_todo.push_back(M_GRID);
                    m_todo.push_back(M_LEVEL);
                    model_enter(M_CLEAR);
                end
            end
            M_PLAY: begin
                if (go || m_po) begin
                    m_po = 0;
                    m_pr = 0;
                    model_enter(M_END);
                end else if (rr || m_pr) begin
                    m_pr = 0;
                    model_enter(M_NUM);
                end
            end
            default: begin
                if (m_ph != M_END) begin
                    m_po = m_po | go;
                    m_pr = m_pr | rr;
                end
                m_left--;
                if (m_left == 0) begin
                    if (m_todo.size() > 0) begin
                        model_enter(m_todo.pop_front());
                    end else if (m_ph == M_END) begin
                        m_ph   = M_IDLE;
                        m_diff = 2'b00;
                        m_po   = 0;
                        m_pr   = 0;
                    end else begin
                        m_ll = (m_ph == M_LEVEL);
                        m_ph = M_PLAY;
                    end
                end
            end
        endcase
    endtask

    function automatic logic [9:0] exp_vec();
        logic c, g, ez, nm, hd, nu, bz, rd;
        c  = (m_ph == M_CLEAR) || (m_ph == M_END);
        g  = (m_ph == M_GRID);
        ez = (m_ph == M_LEVEL) && (m_diff == 2'd0);
        nm = (m_ph == M_LEVEL) && (m_diff == 2'd1);
        hd = (m_ph == M_LEVEL) && (m_diff >= 2'd2);
        nu = (m_ph == M_NUM);
        bz = (m_ph != M_IDLE) && (m_ph != M_PLAY);
        rd = (m_ph == M_PLAY);
        return {c, g, ez, nm, hd, nu, c | g | ez | nm | hd | nu, bz, rd, m_ll};
    endfunction

    // Drive one cycle of inputs, step the model at the edge, and return
    // 1 time unit later so outputs are sampled away from the edge.
    task automatic tick(input bit st, input logic [1:0] d, input bit rr, input bit go);
        start      = st;
        difficulty = d;
        redraw_req = rr;
        game_over  = go;
        @(posedge clk);
        model_step(st, d, rr, go);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(0, 2'b00, 0, 0);
        model_reset();
        tick(0, 2'b00, 0, 0);
        model_reset();
        checks++;
        if (obs !== 10'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 10'b0);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick(0, 2'b00, 0, 0);
        checks++;
        if (obs !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL reset_idle: got %b expected %b", obs, exp_vec());
        end
    endtask

    task automatic test_normal_sequence();
        logic [4:0] win;
        for (int c = 1; c <= 19; c++) begin
            if (c == 1) tick(1, 2'b01, 0, 0);
            else        tick(0, 2'($urandom_range(0, 3)), 0, 0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL normal_model c=%0d: got %b expected %b", c, obs, exp_vec());
            end
            win = {c <= 8, c >= 9 && c <= 12, c >= 13 && c <= 18, c == 19, c == 19};
            checks++;
            if ({clear, drawGrid, drawNORMAL, level_loaded, ready} !== win ||
                drawEZ || drawHARD || drawNum || plot !== (c <= 18)) begin
                failures++;
                $display("[TB] FAIL normal_window c=%0d: got clr/grd/nrm/ll/rdy=%b plot=%b expected %b",
                         c, {clear, drawGrid, drawNORMAL, level_loaded, ready}, plot, win);
            end
        end
    endtask

    task automatic test_levels();
        logic [1:0] d;
        int hits, wrong;
        bit st, go;
        for (int k = 0; k < 2; k++) begin
            d     = (k == 0) ? 2'b11 : 2'b00;
            hits  = 0;
            wrong = 0;
            for (int c = 0; c < 40; c++) begin
                st = (c == 10);
                go = (c == 0);
                tick(st, st ? d : 2'($urandom_range(0, 3)), 0, go);
                checks++;
                if (obs !== exp_vec()) begin
                    failures++;
                    $display("[TB] FAIL level_model d=%0d c=%0d: got %b expected %b", d, c, obs, exp_vec());
                end
                if ((d == 2'b11) ? drawHARD : drawEZ) hits++;
                if (((d == 2'b11) ? drawEZ : drawHARD) || drawNORMAL) wrong++;
            end
            checks++;
            if (hits != NUM_N || wrong != 0) begin
                failures++;
                $display("[TB] FAIL level_board d=%0d: got %0d cycles (%0d wrong) expected %0d (0 wrong)",
                         d, hits, wrong, NUM_N);
            end
        end
    endtask

    task automatic test_redraw_collapse();
        int nums;
        bit rr;
        nums = 0;
        for (int c = 0; c < 20; c++) begin
            rr = (c == 0) || (c == 1) || (c == 2) || (c == 4);
            tick(0, 2'b00, rr, 0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL redraw_model c=%0d: got %b expected %b", c, obs, exp_vec());
            end
            checks++;
            if (drawNum !== ((c <= 5) || (c >= 7 && c <= 12))) begin
                failures++;
                $display("[TB] FAIL redraw_window c=%0d: got drawNum=%b expected %b",
                         c, drawNum, (c <= 5) || (c >= 7 && c <= 12));
            end
            if (drawNum) nums++;
        end
        checks++;
        if (nums != 2 * NUM_N) begin
            failures++;
            $display("[TB] FAIL redraw_count: got %0d expected %0d", nums, 2 * NUM_N);
        end
    endtask

    task automatic test_over_and_redraw();
        for (int c = 0; c < 12; c++) begin
            tick(c == 3, 2'b01, c == 0, c == 0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL over_model c=%0d: got %b expected %b", c, obs, exp_vec());
            end
            checks++;
            if (clear !== (c <= 7) || drawNum !== 1'b0 || busy !== (c <= 7) || ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL over_window c=%0d: got clr/num/busy/rdy=%b%b%b%b expected %b000",
                         c, clear, drawNum, busy, ready, c <= 7);
            end
        end
    endtask

    task automatic test_over_during_num();
        int nums;
        nums = 0;
        for (int c = 0; c < 36; c++) begin
            tick((c == 0) || (c == 10), 2'($urandom_range(0, 3)), c == 19, c == 21);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL num_over_model c=%0d: got %b expected %b", c, obs, exp_vec());
            end
            checks++;
            if (ready !== (c == 18 || c == 25) ||
                clear !== (c <= 7 || (c >= 26 && c <= 33))) begin
                failures++;
                $display("[TB] FAIL num_over_window c=%0d: got rdy/clr=%b%b expected %b%b",
                         c, ready, clear, c == 18 || c == 25, c <= 7 || (c >= 26 && c <= 33));
            end
            if (drawNum) nums++;
        end
        checks++;
        if (nums != NUM_N) begin
            failures++;
            $display("[TB] FAIL num_over_count: got %0d expected %0d", nums, NUM_N);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c <= 10; c++) tick(c == 0, 2'b10, 0, 0);
        checks++;
        if (drawGrid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset_grid: got %b expected 1", drawGrid);
        end
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 10'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got %b expected %b", obs, 10'b0);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick(c == 5, 2'b00, 0, 0);
            checks++;
            if (obs !== exp_vec() || clear !== (c >= 5 && c <= 12)) begin
                failures++;
                $display("[TB] FAIL after_reset c=%0d: got %b expected %b", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit st, rr, go;
        for (int c = 0; c < 800; c++) begin
            st = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 7) == 0);
            go = ($urandom_range(0, 39) == 0);
            tick(st, 2'($urandom_range(0, 3)), rr, go);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL random c=%0d: got %b expected %b", c, obs, exp_vec());
            end
        end
    endtask

    // Scenario sequence; each task leaves the design in the state the next
    // one expects (PLAY after the level tests, IDLE after end-of-game).
    initial begin
        start      = 1'b0;
        difficulty = 2'b00;
        redraw_req = 1'b0;
        game_over  = 1'b0;
        model_reset();
        test_reset();
        test_normal_sequence();
        test_levels();
        test_redraw_collapse();
        test_over_and_redraw();
        test_over_during_num();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
